multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: main FSM plus ALU and immediate decoders.
// Latency: outputs combinational from state/instruction fields; state advances one step per clk.
// Backpressure: none; every state lasts exactly one cycle.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        aluop     = 2'b00;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                state_nxt = S_DECODE;
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcupdate  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYP:      state_nxt = S_EXECUTER;
                    OP_ITYP:      state_nxt = S_EXECUTEI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
            end
            S_MEMREAD: begin
                state_nxt = S_MEMWB;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                state_nxt = S_ALUWB;
                ALUSrcA   = 2'b10;
                aluop     = 2'b10;
            end
            S_EXECUTEI: begin
                state_nxt = S_ALUWB;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                aluop     = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                // PC <= PC+imm while ALU computes OldPC+4 for the link register
                state_nxt = S_ALUWB;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcupdate  = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign PCWrite = pcupdate | (branch & Zero);
    assign State   = state;

    always_comb begin
        case (op)
            OP_LW, OP_ITYP: ImmSrc = 2'b00;
            OP_SW:          ImmSrc = 2'b01;
            OP_BEQ:         ImmSrc = 2'b10;
            OP_JAL:         ImmSrc = 2'b11;
            default:        ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // funct7b5 only means sub for R-type; addi ignores it
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: per-cycle table plus async reset sequence.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    localparam int LW = 'b0000011;
    localparam int SW = 'b0100011;
    localparam int RT = 'b0110011;
    localparam int IT = 'b0010011;
    localparam int JL = 'b1101111;
    localparam int BQ = 'b1100011;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
    } vec_t;

    vec_t vecs[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int rst, input int o, input int f3, input int f7, input int z,
                        input int st, input int pcw, input int adr, input int mw, input int irw,
                        input int rw, input int rs, input int sa, input int sb, input int imm,
                        input int alu);
        vec_t v;
        v.rst = 1'(rst); v.op = 7'(o); v.f3 = 3'(f3); v.f7 = 1'(f7); v.z = 1'(z);
        v.st = 4'(st); v.pcw = 1'(pcw); v.adr = 1'(adr); v.mw = 1'(mw); v.irw = 1'(irw);
        v.rw = 1'(rw); v.rs = 2'(rs); v.sa = 2'(sa); v.sb = 2'(sb); v.imm = 2'(imm);
        v.alu = 3'(alu);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        // rst, op, f3, f7, z | st, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu
        push(1, LW, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(1, LW, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        // lw: 0,1,2,3,4
        push(0, LW, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, LW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, LW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        push(0, LW, 0, 0, 0,   3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, LW, 0, 0, 0,   4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // sw: 0,1,2,5
        push(0, SW, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 1, 0);
        push(0, SW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        push(0, SW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        push(0, SW, 0, 0, 0,   5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        // sub
        push(0, RT, 0, 1, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, RT, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, RT, 0, 1, 0,   6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
        push(0, RT, 0, 1, 0,   7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // add
        push(0, RT, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, RT, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, RT, 0, 0, 0,   6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        push(0, RT, 0, 0, 0,   7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // and, Zero high must not leak into PCWrite
        push(0, RT, 7, 0, 1,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, RT, 7, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, RT, 7, 0, 1,   6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2);
        push(0, RT, 7, 0, 1,   7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // addi with funct7b5=1 stays add
        push(0, IT, 0, 1, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, IT, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, IT, 0, 1, 0,   8, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        push(0, IT, 0, 1, 0,   7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // slti
        push(0, IT, 2, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, IT, 2, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, IT, 2, 0, 0,   8, 0, 0, 0, 0, 0, 0, 2, 1, 0, 5);
        push(0, IT, 2, 0, 0,   7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // ori
        push(0, IT, 6, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0, IT, 6, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, IT, 6, 0, 0,   8, 0, 0, 0, 0, 0, 0, 2, 1, 0, 3);
        push(0, IT, 6, 0, 0,   7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // jal: 0,1,9,7
        push(0, JL, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 3, 0);
        push(0, JL, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0);
        push(0, JL, 0, 0, 0,   9, 1, 0, 0, 0, 0, 0, 1, 2, 3, 0);
        push(0, JL, 0, 0, 0,   7, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
        // beq taken
        push(0, BQ, 0, 0, 1,   0, 1, 0, 0, 1, 0, 2, 0, 2, 2, 0);
        push(0, BQ, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
        push(0, BQ, 0, 0, 1,  10, 1, 0, 0, 0, 0, 0, 2, 0, 2, 1);
        // beq not taken
        push(0, BQ, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 2, 0);
        push(0, BQ, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
        push(0, BQ, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0, 2, 0, 2, 1);
        // unsupported opcode: 0,1,0
        push(0,  0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);
        push(0,  0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0,  0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0);

        reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; Zero = vecs[i].z;
            @(negedge clk);
            check("State",      i, 8'(State),      8'(vecs[i].st));
            check("PCWrite",    i, 8'(PCWrite),    8'(vecs[i].pcw));
            check("AdrSrc",     i, 8'(AdrSrc),     8'(vecs[i].adr));
            check("MemWrite",   i, 8'(MemWrite),   8'(vecs[i].mw));
            check("IRWrite",    i, 8'(IRWrite),    8'(vecs[i].irw));
            check("RegWrite",   i, 8'(RegWrite),   8'(vecs[i].rw));
            check("ResultSrc",  i, 8'(ResultSrc),  8'(vecs[i].rs));
            check("ALUSrcA",    i, 8'(ALUSrcA),    8'(vecs[i].sa));
            check("ALUSrcB",    i, 8'(ALUSrcB),    8'(vecs[i].sb));
            check("ImmSrc",     i, 8'(ImmSrc),     8'(vecs[i].imm));
            check("ALUControl", i, 8'(ALUControl), 8'(vecs[i].alu));
            @(posedge clk);
            #1;
        end

        // Reset mid-decode takes effect without a clock edge
        reset = 1'b1; op = 7'(LW); funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        #1;
        check("async_rst_decode", 100, 8'(State), 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("lw_decode", 101, 8'(State), 8'd1);
        @(posedge clk); #1;
        check("lw_memadr", 102, 8'(State), 8'd2);
        @(posedge clk); #1;
        check("lw_memread", 103, 8'(State), 8'd3);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_rst_state", 104, 8'(State), 8'd0);
        check("async_rst_regwrite", 104, 8'(RegWrite), 8'd0);
        check("async_rst_irwrite", 104, 8'(IRWrite), 8'd1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("rst_hold_state", 105 + k, 8'(State), 8'd0);
            check("rst_hold_regwrite", 105 + k, 8'(RegWrite), 8'd0);
            check("rst_hold_memwrite", 105 + k, 8'(MemWrite), 8'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", 107, 8'(State), 8'd0);
        check("post_rst_regwrite", 107, 8'(RegWrite), 8'd0);
        @(posedge clk); #1;
        check("post_rst_decode", 108, 8'(State), 8'd1);
        check("post_rst_regwrite", 108, 8'(RegWrite), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
